// File: rtl/risc16_pkg.sv
// Shared RiSC-16 types and constants used by the fetch and decode stages.
package risc16_pkg;

    typedef logic [15:0] word_t;

    localparam word_t NOP_INSTR = 16'h0000;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    // Opcode field (instr[15:13]) values, shared with decode.
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b001;
    localparam logic [2:0] OP_NAND = 3'b010;
    localparam logic [2:0] OP_LUI  = 3'b011;
    localparam logic [2:0] OP_SW   = 3'b100;
    localparam logic [2:0] OP_LW   = 3'b101;
    localparam logic [2:0] OP_BEQ  = 3'b110;
    localparam logic [2:0] OP_JALR = 3'b111;

    function automatic logic [2:0] opcode_of(input word_t instr);
        return instr[15:13];
    endfunction

endpackage

// File: rtl/risc16_fetch_stage.sv
// RiSC-16 instruction fetch: PC register, IF/ID pipeline register and
// accepted-instruction counter, with redirect/halt/stall control.
//
// Control semantics (sampled on each rising clk edge while in RUN):
//   redirect_valid  - squashes the IF/ID slot and loads redirect_pc; wins
//                     over halt and stall because anything younger is dead.
//   halt            - squashes the IF/ID slot, freezes PC, enters HALTED.
//   stall           - PC, IF/ID and fetch_count hold.
//   none of them    - the word at imem_pc is accepted into IF/ID and the
//                     PC advances by one.
// HALTED ignores every input; only rst_n leaves it.
module risc16_fetch_stage
    import risc16_pkg::*;
#(
    parameter word_t RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] imem_pc,
    input  logic [15:0] imem_instr,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    input  logic        halt,
    output logic        id_valid,
    output logic [15:0] id_instr,
    output logic [15:0] id_pc,
    output logic [15:0] id_pc_plus1,
    output logic        halted,
    output logic [31:0] fetch_count
);

    fetch_state_t state, state_nxt;
    word_t        pc, pc_nxt;
    logic         valid_nxt;
    word_t        instr_nxt, id_pc_nxt, id_pc_plus1_nxt;
    logic [31:0]  count_nxt;

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            pc          <= RESET_PC;
            id_valid    <= 1'b0;
            id_instr    <= NOP_INSTR;
            id_pc       <= 16'h0000;
            id_pc_plus1 <= 16'h0000;
            fetch_count <= 32'd0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            id_valid    <= valid_nxt;
            id_instr    <= instr_nxt;
            id_pc       <= id_pc_nxt;
            id_pc_plus1 <= id_pc_plus1_nxt;
            fetch_count <= count_nxt;
        end
    end

    // Next-state and next-register selection, priority redirect > halt > stall.
    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        valid_nxt       = id_valid;
        instr_nxt       = id_instr;
        id_pc_nxt       = id_pc;
        id_pc_plus1_nxt = id_pc_plus1;
        count_nxt       = fetch_count;
        case (state)
            RUN: begin
                if (redirect_valid) begin
                    pc_nxt    = redirect_pc;
                    valid_nxt = 1'b0;
                    instr_nxt = NOP_INSTR;
                end else if (halt) begin
                    valid_nxt = 1'b0;
                    instr_nxt = NOP_INSTR;
                    state_nxt = HALTED;
                end else if (!stall) begin
                    instr_nxt       = imem_instr;
                    id_pc_nxt       = pc;
                    id_pc_plus1_nxt = pc + 16'd1;
                    valid_nxt       = 1'b1;
                    pc_nxt          = pc + 16'd1;
                    count_nxt       = fetch_count + 32'd1;
                end
            end
            HALTED: begin
                // Frozen until reset.
            end
            default: state_nxt = RUN;
        endcase
    end

    assign imem_pc = pc;
    assign halted  = (state == HALTED);

endmodule

// File: tb/tb_risc16_fetch_stage.sv
// Directed bench for risc16_fetch_stage: main instance at RESET_PC=0 and a
// second instance at RESET_PC=FFFE for the PC wrap case.
module tb_risc16_fetch_stage;

    int total = 0;
    int bad   = 0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] imem_pc;
    logic [15:0] imem_instr;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        halt = 1'b0;
    logic        id_valid;
    logic [15:0] id_instr, id_pc, id_pc_plus1;
    logic        halted;
    logic [31:0] fetch_count;

    logic        rst1_n = 1'b0;
    logic [15:0] imem_pc1, imem_instr1;
    logic        id_valid1;
    logic [15:0] id_instr1, id_pc1, id_pc_plus1_1;
    logic        halted1;
    logic [31:0] fetch_count1;

    // Clock
    always #5 clk = ~clk;

    // Instruction memory contents: a few fixed words, otherwise {addr[7:0], 5A}.
    function automatic logic [15:0] mem(input logic [15:0] a);
        case (a)
            16'h0000: return 16'h1111;
            16'h0001: return 16'h2222;
            16'h0002: return 16'h3333;
            16'h0040: return 16'h4040;
            default:  return {a[7:0], 8'h5A};
        endcase
    endfunction

    assign imem_instr  = mem(imem_pc);
    assign imem_instr1 = mem(imem_pc1);

    risc16_fetch_stage #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .imem_pc(imem_pc), .imem_instr(imem_instr),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt(halt), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
        .id_pc_plus1(id_pc_plus1), .halted(halted), .fetch_count(fetch_count)
    );

    risc16_fetch_stage #(.RESET_PC(16'hFFFE)) dut_wrap (
        .clk(clk), .rst_n(rst1_n), .imem_pc(imem_pc1), .imem_instr(imem_instr1),
        .stall(1'b0), .redirect_valid(1'b0), .redirect_pc(16'h0000),
        .halt(1'b0), .id_valid(id_valid1), .id_instr(id_instr1), .id_pc(id_pc1),
        .id_pc_plus1(id_pc_plus1_1), .halted(halted1), .fetch_count(fetch_count1)
    );

    // Advance one rising edge; outputs are then sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        total++; if (imem_pc !== 16'h0000) begin bad++; $display("FAIL reset_imem_pc got=%h exp=0000", imem_pc); end
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", id_valid); end
        total++; if (id_instr !== 16'h0000) begin bad++; $display("FAIL reset_instr got=%h exp=0000", id_instr); end
        total++; if (id_pc !== 16'h0000 || id_pc_plus1 !== 16'h0000) begin bad++; $display("FAIL reset_id_pc got=%h/%h exp=0000/0000", id_pc, id_pc_plus1); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b exp=0", halted); end
        total++; if (fetch_count !== 32'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", fetch_count); end
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        step();
        total++; if (id_instr !== 16'h1111 || id_pc !== 16'h0000 || id_pc_plus1 !== 16'h0001 || id_valid !== 1'b1)
            begin bad++; $display("FAIL seq0 got=%h pc=%h pc1=%h v=%b exp=1111/0000/0001/1", id_instr, id_pc, id_pc_plus1, id_valid); end
        step();
        total++; if (id_instr !== 16'h2222 || id_pc !== 16'h0001 || id_pc_plus1 !== 16'h0002)
            begin bad++; $display("FAIL seq1 got=%h pc=%h pc1=%h exp=2222/0001/0002", id_instr, id_pc, id_pc_plus1); end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            total++; if (id_instr !== 16'h2222 || id_pc !== 16'h0001 || imem_pc !== 16'h0002 || fetch_count !== 32'd2)
                begin bad++; $display("FAIL stall%0d got=%h pc=%h imem=%h cnt=%0d exp=2222/0001/0002/2", i, id_instr, id_pc, imem_pc, fetch_count); end
        end
        stall = 1'b0;
        step();
        total++; if (id_instr !== 16'h3333 || id_pc !== 16'h0002 || id_pc_plus1 !== 16'h0003 || fetch_count !== 32'd3)
            begin bad++; $display("FAIL stall_release got=%h pc=%h pc1=%h cnt=%0d exp=3333/0002/0003/3", id_instr, id_pc, id_pc_plus1, fetch_count); end
    endtask

    task automatic test_redirect();
        redirect_valid = 1'b1;
        redirect_pc = 16'h0040;
        stall = 1'b1;
        step();
        total++; if (id_valid !== 1'b0 || id_instr !== 16'h0000 || imem_pc !== 16'h0040 || fetch_count !== 32'd3)
            begin bad++; $display("FAIL redir_bubble got v=%b i=%h imem=%h cnt=%0d exp=0/0000/0040/3", id_valid, id_instr, imem_pc, fetch_count); end
        redirect_valid = 1'b0;
        stall = 1'b0;
        step();
        total++; if (id_valid !== 1'b1 || id_pc !== 16'h0040 || id_instr !== 16'h4040 || id_pc_plus1 !== 16'h0041 || fetch_count !== 32'd4)
            begin bad++; $display("FAIL redir_target got v=%b pc=%h i=%h pc1=%h cnt=%0d exp=1/0040/4040/0041/4", id_valid, id_pc, id_instr, id_pc_plus1, fetch_count); end
    endtask

    task automatic test_halt_with_redirect();
        halt = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 16'h0010;
        step();
        total++; if (halted !== 1'b0 || id_valid !== 1'b0 || imem_pc !== 16'h0010)
            begin bad++; $display("FAIL halt_redir got h=%b v=%b imem=%h exp=0/0/0010", halted, id_valid, imem_pc); end
        halt = 1'b0;
        redirect_valid = 1'b0;
        step();
        total++; if (halted !== 1'b0 || id_valid !== 1'b1 || id_pc !== 16'h0010 || id_instr !== 16'h105A || fetch_count !== 32'd5)
            begin bad++; $display("FAIL halt_redir_resume got h=%b v=%b pc=%h i=%h cnt=%0d exp=0/1/0010/105A/5", halted, id_valid, id_pc, id_instr, fetch_count); end
    endtask

    task automatic test_halt();
        halt = 1'b1;
        step();
        total++; if (halted !== 1'b1 || id_valid !== 1'b0 || id_instr !== 16'h0000 || imem_pc !== 16'h0011 || fetch_count !== 32'd5)
            begin bad++; $display("FAIL halt_enter got h=%b v=%b i=%h imem=%h cnt=%0d exp=1/0/0000/0011/5", halted, id_valid, id_instr, imem_pc, fetch_count); end
        halt = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 16'h0080;
        for (int i = 0; i < 3; i++) begin
            stall = (i == 1);
            step();
            total++; if (halted !== 1'b1 || id_valid !== 1'b0 || imem_pc !== 16'h0011 || fetch_count !== 32'd5)
                begin bad++; $display("FAIL halt_hold%0d got h=%b v=%b imem=%h cnt=%0d exp=1/0/0011/5", i, halted, id_valid, imem_pc, fetch_count); end
        end
        redirect_valid = 1'b0;
        stall = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (halted !== 1'b0 || imem_pc !== 16'h0000 || fetch_count !== 32'd0 || id_pc !== 16'h0000)
            begin bad++; $display("FAIL async_reset got h=%b imem=%h cnt=%0d pc=%h exp=0/0000/0/0000", halted, imem_pc, fetch_count, id_pc); end
        #2;
        rst_n = 1'b1;
        step();
        total++; if (id_instr !== 16'h1111 || id_pc !== 16'h0000 || id_valid !== 1'b1 || fetch_count !== 32'd1)
            begin bad++; $display("FAIL post_reset got i=%h pc=%h v=%b cnt=%0d exp=1111/0000/1/1", id_instr, id_pc, id_valid, fetch_count); end
    endtask

    task automatic test_pc_wrap();
        rst1_n = 1'b1;
        step();
        total++; if (id_pc1 !== 16'hFFFE || id_pc_plus1_1 !== 16'hFFFF || id_instr1 !== 16'hFE5A)
            begin bad++; $display("FAIL wrap0 got pc=%h pc1=%h i=%h exp=FFFE/FFFF/FE5A", id_pc1, id_pc_plus1_1, id_instr1); end
        step();
        total++; if (id_pc1 !== 16'hFFFF || id_pc_plus1_1 !== 16'h0000 || id_instr1 !== 16'hFF5A)
            begin bad++; $display("FAIL wrap1 got pc=%h pc1=%h i=%h exp=FFFF/0000/FF5A", id_pc1, id_pc_plus1_1, id_instr1); end
        step();
        total++; if (id_pc1 !== 16'h0000 || id_pc_plus1_1 !== 16'h0001 || id_instr1 !== 16'h1111 || fetch_count1 !== 32'd3)
            begin bad++; $display("FAIL wrap2 got pc=%h pc1=%h i=%h cnt=%0d exp=0000/0001/1111/3", id_pc1, id_pc_plus1_1, id_instr1, fetch_count1); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_halt_with_redirect();
        test_halt();
        test_pc_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/risc16_fetch_stage.md
# risc16_fetch_stage

Instruction-fetch stage of the RiSC-16 core. Owns the program counter and drives the combinational-read instruction memory. Captures the returned word into the IF/ID pipeline register together with its PC and PC+1 for the decode stage. Handles stall, branch/jump redirect from execute, and halt; the instruction memory itself is instantiated beside this block in the core top.

## Interface
- `RESET_PC`, default 16'h0000: PC value loaded on reset.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `imem_pc` out 16: word address to instruction memory.
- `imem_instr` in 16: instruction word read combinationally at `imem_pc`.
- `stall` in 1: hold PC and IF/ID register (decode hazard).
- `redirect_valid` in 1: execute resolved a taken BEQ/JALR; refetch from `redirect_pc`.
- `redirect_pc` in 16: redirect target.
- `halt` in 1: decode holds a HALT; stop fetching.
- `id_valid` out 1: IF/ID register holds a live instruction.
- `id_instr` out 16: latched instruction; NOP (16'h0000) when not valid.
- `id_pc` out 16: PC of `id_instr`.
- `id_pc_plus1` out 16: `id_pc + 1`, mod 2^16.
- `halted` out 1: block is in HALTED.
- `fetch_count` out 32: number of instructions accepted into IF/ID.

## Operation
- States: RUN, HALTED. Reset enters RUN. RUN -> HALTED on `halt` when `redirect_valid` is 0. HALTED is left only by reset.
- Per-edge priority in RUN: redirect > halt > stall > normal.
- Redirect:
  - `pc <= redirect_pc`.
  - `id_valid <= 0`, `id_instr <= NOP`.
  - Overrides `stall` and `halt`, because the halting instruction is younger and is squashed.
- Halt:
  - `id_valid <= 0`, `id_instr <= NOP`.
  - PC frozen.
  - Enter HALTED.
- Stall: PC, IF/ID register and `fetch_count` all hold their values.
- Normal:
  - `id_instr <= imem_instr`, `id_pc <= pc`, `id_pc_plus1 <= pc + 1`, `id_valid <= 1`.
  - `pc <= pc + 1`.
  - `fetch_count` increments by 1.
- HALTED:
  - All inputs except `rst_n` are ignored.
  - PC, IF/ID register and `fetch_count` frozen.
  - `id_valid` = 0, `halted` = 1.
- Arithmetic:
  - PC is 16-bit and word-addressed; 16'hFFFF + 1 wraps to 16'h0000 with no flag.
  - `fetch_count` wraps from 2^32-1 to 0.
- `imem_pc` is the PC register directly, with no combinational path from `redirect_pc`.

## Timing
- Reset values: `pc` = `RESET_PC`, so `imem_pc` = `RESET_PC`. `id_valid` = 0, `id_instr` = 0, `id_pc` = 0, `id_pc_plus1` = 0, `halted` = 0, `fetch_count` = 0.
- Reset assertion clears all state immediately, mid-stall or mid-halt included. The first edge after deassertion latches the instruction at `RESET_PC`.
- Fetch latency: 1 cycle from `imem_pc` to `id_instr`. Throughput is 1 instruction per cycle when not stalled.
- Redirect penalty:
  - Edge N samples `redirect_valid` and inserts a bubble.
  - Edge N+1 latches the target instruction, and `id_valid` = 1 after N+1.
- Halt: `halted` and `id_valid` = 0 are visible after the edge that samples `halt`.
- `stall` and `redirect_valid` both high: redirect is taken and the stall is dropped for that edge.

## Structure
- Shared package `risc16_pkg`:
  - `word_t` (16-bit) type.
  - `NOP_INSTR` = 16'h0000.
  - `fetch_state_t` enum {RUN, HALTED}.
  - Opcode field constants, shared with decode.
- No sub-module is required; PC logic, IF/ID register and counter stay flat in one module.

## Test plan
- Reset release with `RESET_PC`=0 and memory 0:1111, 1:2222, 2:3333 -> `id_instr` 1111/2222/3333 on successive cycles, `id_pc` 0/1/2, `id_pc_plus1` 1/2/3, `fetch_count` 3.
- `stall` high 2 cycles while `id_instr`=2222 -> `id_instr`, `id_pc`=1 and `imem_pc`=2 all held. After release the next value is 3333.
- `redirect_valid`=1 with `redirect_pc`=16'h0040 and `stall`=1 -> one bubble (`id_valid`=0, `id_instr`=0). Next cycle `id_pc`=16'h0040, valid.
- `RESET_PC`=16'hFFFE, run 3 cycles -> `id_pc` FFFE, FFFF, 0000, and `id_pc_plus1` of FFFF is 0000.
- `halt` asserted -> `halted`=1 and `id_valid`=0 next cycle. Later redirects and stalls are ignored and `fetch_count` is frozen. Asserting `rst_n`=0 mid-cycle clears `halted` asynchronously.
- `halt` and `redirect_valid` together -> no halt. Fetch resumes at `redirect_pc` and `halted` stays 0.
